// File: rtl/spi_frame_sequencer_pkg.sv
// Shared types and constants for the SPI slave frame sequencer.
package spi_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } spi_frame_state_t;

    // Status LEDs are active low: bit 1 green (ok), bit 0 red (error).
    localparam logic [1:0] LED_OFF = 2'b11;
    localparam logic [1:0] LED_OK  = 2'b01;
    localparam logic [1:0] LED_ERR = 2'b10;

    // End-of-frame integrity audit: whole words only, within ceiling, no lost word.
    function automatic logic frame_audit(input int unsigned cnt,
                                         input int unsigned word_bits,
                                         input int unsigned max_bits,
                                         input logic        overrun);
        return (cnt != 0) && ((cnt % word_bits) == 0) && (cnt <= max_bits) && !overrun;
    endfunction

endpackage

// File: rtl/spi_frame_sequencer_led_hold_timer.sv
// Reloadable down-counter that times how long the result LEDs stay lit.
// done_o marks the last counted cycle; busy_o is high while any count remains.
module led_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on start, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CW'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/spi_frame_sequencer.sv
// Frame-level controller for the SPI slave receive path: shifts filtered bits,
// hands whole words off over valid/ready, audits each CS-framed transaction and
// shows the result on the active-low status LEDs for a hold time.
module spi_frame_sequencer
    import spi_frame_sequencer_pkg::*;
#(
    parameter int unsigned WORD_BITS   = 8,
    parameter int unsigned MAX_BITS    = 256,
    parameter int unsigned HOLD_CYCLES = 12_500_000
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          cs_n,
    input  logic                          sck_rise,
    input  logic                          mosi,
    output logic [WORD_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(MAX_BITS+2)-1:0] bit_cnt,
    output logic                          frame_done,
    output logic                          frame_ok,
    output logic [1:0]                    led
);

    localparam int unsigned CNT_W  = $clog2(MAX_BITS + 2);
    localparam int unsigned WCNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    spi_frame_state_t state_q, state_d;

    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 overrun_q, overrun_d;
    logic [WORD_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_ok_q, frame_ok_d;
    logic [1:0]           led_q, led_d;

    logic enter_active, to_check, led_off;
    logic bit_accept, word_done, audit_ok;
    logic tmr_busy, tmr_done;

    // Timer starts on the edge into CHECK so the LEDs stay lit exactly HOLD_CYCLES.
    led_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk_i  (clk_in),
        .rst_i  (rst),
        .start_i(to_check),
        .busy_o (tmr_busy),
        .done_o (tmr_done)
    );

    // CS release dominates a coincident SCK edge, so bits count only while cs_n stays low.
    assign bit_accept = (state_q == ACTIVE) && !cs_n && sck_rise;
    assign audit_ok   = frame_audit(32'(bit_cnt_q), WORD_BITS, MAX_BITS, overrun_q);

    // Next-state logic and FSM control strobes.
    always_comb begin
        state_d      = state_q;
        enter_active = 1'b0;
        to_check     = 1'b0;
        led_off      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_n) begin
                    state_d      = ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_n) begin
                    state_d  = CHECK;
                    to_check = 1'b1;
                end
            end
            CHECK: begin
                state_d = REPORT;
            end
            REPORT: begin
                // A new frame cuts the hold short and restarts reception at once.
                if (!cs_n) begin
                    state_d      = ACTIVE;
                    enter_active = 1'b1;
                    led_off      = 1'b1;
                end else if (tmr_done || !tmr_busy) begin
                    state_d = IDLE;
                    led_off = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shifter, counters, output word register and audit/LED results.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        wcnt_d       = wcnt_q;
        overrun_d    = overrun_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        led_d        = led_q;
        word_done    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (enter_active) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            wcnt_d    = '0;
            overrun_d = 1'b0;
        end else if (bit_accept) begin
            shift_d = {shift_q[WORD_BITS-2:0], mosi};
            if (bit_cnt_q != CNT_W'(MAX_BITS + 1)) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            if (wcnt_q == WCNT_W'(WORD_BITS - 1)) begin
                wcnt_d    = '0;
                word_done = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
            end
        end

        // A completed word always loads; it only counts as lost if the old one was not taken.
        if (word_done) begin
            rx_data_d  = {shift_q[WORD_BITS-2:0], mosi};
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end
        end

        if (to_check) begin
            frame_done_d = 1'b1;
            frame_ok_d   = audit_ok;
            led_d        = audit_ok ? LED_OK : LED_ERR;
        end

        if (led_off) begin
            led_d = LED_OFF;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            wcnt_q       <= '0;
            overrun_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            led_q        <= LED_OFF;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            wcnt_q       <= wcnt_d;
            overrun_q    <= overrun_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            led_q        <= led_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign bit_cnt    = bit_cnt_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign led        = led_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: stimulus pushes expected words and
// frame audits computed from frame-level rules; a monitor pops and compares them.
module tb_spi_frame_sequencer;

    localparam int unsigned WB   = 8;
    localparam int unsigned MAXB = 24;
    localparam int unsigned HOLD = 16;
    localparam int unsigned CW   = $clog2(MAXB + 2);

    localparam logic [1:0] L_OFF = 2'b11;
    localparam logic [1:0] L_OK  = 2'b01;
    localparam logic [1:0] L_ERR = 2'b10;

    typedef struct packed {
        logic          ok;
        logic [CW-1:0] cnt;
        logic [1:0]    led;
    } exp_frame_t;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          cs_n;
    logic          sck_rise;
    logic          mosi;
    logic [WB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] bit_cnt;
    logic          frame_done;
    logic          frame_ok;
    logic [1:0]    led;

    int checks = 0;
    int errors = 0;

    logic [WB-1:0] word_q[$];
    exp_frame_t    frame_q[$];

    spi_frame_sequencer #(
        .WORD_BITS  (WB),
        .MAX_BITS   (MAXB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cs_n      (cs_n),
        .sck_rise  (sck_rise),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .bit_cnt   (bit_cnt),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .led       (led)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Frame-level reference: whole words in arrival order; with the consumer
    // stalled only the last word survives and two or more words mean overrun.
    task automatic push_expect(input logic [63:0] bits, input int n, input logic rdy);
        int         words;
        logic       ovr;
        exp_frame_t e;
        words = n / WB;
        ovr   = !rdy && (words >= 2);
        if (rdy) begin
            for (int w = 0; w < words; w++)
                word_q.push_back(WB'(bits >> (n - WB * (w + 1))));
        end else if (words >= 1) begin
            word_q.push_back(WB'(bits >> (n - WB * words)));
        end
        e.ok  = (n != 0) && (n % WB == 0) && (n <= int'(MAXB)) && !ovr;
        e.cnt = (n > int'(MAXB)) ? CW'(MAXB + 1) : CW'(n);
        e.led = e.ok ? L_OK : L_ERR;
        frame_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int gap);
        sck_rise = 1'b1;
        mosi     = b;
        tick();
        sck_rise = 1'b0;
        repeat (gap) tick();
    endtask

    // Drives one frame (MSB first) and returns in the audit cycle.
    task automatic run_frame(input logic [63:0] bits, input int n, input logic rdy,
                             input logic coinc, input logic low_already);
        push_expect(bits, n, rdy);
        rx_ready = rdy;
        if (!low_already) begin
            cs_n = 1'b0;
            tick();
        end
        for (int i = 0; i < n; i++)
            send_bit(bits[n - 1 - i], int'($urandom_range(0, 2)));
        cs_n     = 1'b1;
        sck_rise = coinc;
        mosi     = 1'($urandom);
        tick();
        sck_rise = 1'b0;
    endtask

    task automatic wait_report_end();
        int i;
        for (i = 0; i < 64; i++) begin
            if (led == L_OFF) break;
            tick();
        end
        if (i == 64) begin
            checks++;
            errors++;
            $display("FAIL report_timeout: led still %b after 64 cycles, required %b", led, L_OFF);
        end
    endtask

    task automatic drain();
        int i;
        rx_ready = 1'b1;
        for (i = 0; i < 8; i++) begin
            tick();
            if (!rx_valid) break;
        end
        if (i == 8) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: rx_valid still %b, required 0", rx_valid);
        end
        rx_ready = 1'b0;
    endtask

    // Monitor: compare every accepted word and every audit against the queues.
    always @(negedge clk_in) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got %02h, required no word", rx_data);
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(word_q.pop_front()));
                end
            end
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL audit_unexpected: got frame_done=1, required no audit");
                end else begin
                    exp_frame_t e;
                    e = frame_q.pop_front();
                    chk("frame_ok", 32'(frame_ok), 32'(e.ok));
                    chk("bit_cnt", 32'(bit_cnt), 32'(e.cnt));
                    chk("audit_led", 32'(led), 32'(e.led));
                end
            end
        end
    end

    initial begin
        int lit;
        rst      = 1'b1;
        cs_n     = 1'b1;
        sck_rise = 1'b0;
        mosi     = 1'b0;
        rx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_ok", 32'(frame_ok), 32'h0);
        chk("rst_led", 32'(led), 32'(L_OFF));
        rst = 1'b0;
        tick();

        // 0xA5 with consumer ready: valid one cycle after the 8th rise, LEDs held 16 cycles.
        push_expect(64'hA5, 8, 1'b1);
        rx_ready = 1'b1;
        cs_n     = 1'b0;
        tick();
        for (int i = 7; i > 0; i--) send_bit(1'(8'hA5 >> i), 0);
        sck_rise = 1'b1;
        mosi     = 1'b1;
        chk("a5_valid_before", 32'(rx_valid), 32'h0);
        tick();
        sck_rise = 1'b0;
        chk("a5_valid_after", 32'(rx_valid), 32'h1);
        chk("a5_data_after", 32'(rx_data), 32'hA5);
        cs_n = 1'b1;
        tick();
        lit = 0;
        for (int i = 0; i < 64; i++) begin
            if (led != L_OK) break;
            lit++;
            tick();
        end
        chk("a5_led_hold_cycles", 32'(lit), 32'(HOLD));
        chk("a5_led_after_hold", 32'(led), 32'(L_OFF));
        chk("a5_frame_ok_held", 32'(frame_ok), 32'h1);
        drain();

        // Single-bit glitch frame: audit fails, no word presented.
        run_frame(64'h1, 1, 1'b1, 1'b0, 1'b0);
        wait_report_end();
        chk("glitch_no_valid", 32'(rx_valid), 32'h0);
        drain();

        // Two bytes with consumer stalled: second byte pending, overrun.
        run_frame(64'h1234, 16, 1'b0, 1'b0, 1'b0);
        wait_report_end();
        chk("stall_pending_valid", 32'(rx_valid), 32'h1);
        chk("stall_pending_data", 32'(rx_data), 32'h34);
        drain();

        // Seven bits with an SCK edge coincident with CS release.
        run_frame(64'h55, 7, 1'b1, 1'b1, 1'b0);
        wait_report_end();
        drain();

        // Abort the hold in REPORT cycle 5, then a new byte.
        run_frame(64'hC3, 8, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        chk("abort_led_before", 32'(led), 32'(L_OK));
        cs_n = 1'b0;
        tick();
        chk("abort_led_after", 32'(led), 32'(L_OFF));
        run_frame(64'h5A, 8, 1'b1, 1'b0, 1'b1);
        wait_report_end();
        drain();

        // Reset after four bits, then a clean 0x3C frame.
        cs_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1);
        rst = 1'b1;
        tick();
        chk("midrst_rx_valid", 32'(rx_valid), 32'h0);
        chk("midrst_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("midrst_frame_ok", 32'(frame_ok), 32'h0);
        chk("midrst_led", 32'(led), 32'(L_OFF));
        chk("midrst_rx_data", 32'(rx_data), 32'h0);
        rst  = 1'b0;
        cs_n = 1'b1;
        repeat (2) tick();
        run_frame(64'h3C, 8, 1'b1, 1'b0, 1'b0);
        wait_report_end();
        drain();

        // Randomized frames: lengths around word multiples, the ceiling and zero.
        for (int f = 0; f < 24; f++) begin
            int          n;
            logic [63:0] bits;
            bits = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       n = 8 * int'($urandom_range(1, 3));
                1:       n = int'($urandom_range(0, 40));
                2:       n = 8 * int'($urandom_range(4, 5));
                default: n = int'($urandom_range(0, 2));
            endcase
            run_frame(bits, n, 1'($urandom), 1'($urandom), 1'b0);
            wait_report_end();
            drain();
        end

        repeat (4) tick();
        chk("words_left", 32'(word_q.size()), 32'h0);
        chk("audits_left", 32'(frame_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
